// File: rtl/ext_pkg.sv
// Shared types and helpers for the width extenders.
// Fill rule: 00 zero, 10 ones, 01/11 replicate the sample MSB.
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_ONES = 2'b10
    } ext_mode_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    // Mode 2'b11 is not a named mode and behaves like sign fill.
    function automatic logic ext_fill(input logic [1:0] mode, input logic msb);
        logic fill;
        if (mode == EXT_ZERO) begin
            fill = 1'b0;
        end else if (mode == EXT_ONES) begin
            fill = 1'b1;
        end else begin
            fill = msb;
        end
        return fill;
    endfunction

endpackage

// File: rtl/ext_fill_unit.sv
// Combinational IN_W -> OUT_W extender; upper bits take the mode-selected fill bit.
module ext_fill_unit
    import ext_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] out_data
);

    genvar gi;

    generate
        for (gi = 0; gi < IN_W; gi++) begin : g_low
            assign out_data[gi] = in_data[gi];
        end

        // With OUT_W == IN_W there are no upper bits and the sample passes through.
        if (OUT_W > IN_W) begin : g_ext
            logic fill;
            assign fill = ext_fill(mode, in_data[IN_W-1]);
            for (gi = IN_W; gi < OUT_W; gi++) begin : g_high
                assign out_data[gi] = fill;
            end
        end
    endgenerate

endmodule

// File: rtl/ext_stream_pipe.sv
// Pipelined width extender with a 2-entry skid buffer and valid/ready on both sides.
// Optional delivery statistics are built when EXT_STATS_EN is defined.
module ext_stream_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef EXT_STATS_EN
    output logic [CNT_W-1:0] cnt_beats,
    output logic [CNT_W-1:0] cnt_neg,
`endif
    output logic [OUT_W-1:0] out_data
);

    generate
        if (IN_W < 1) begin : g_bad_in_w
            $error("ext_stream_pipe: IN_W must be >= 1");
        end
        if (OUT_W < IN_W) begin : g_bad_out_w
            $error("ext_stream_pipe: OUT_W must be >= IN_W");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("ext_stream_pipe: CNT_W must be >= 1");
        end
    endgenerate

    occ_state_e       state_reg, state_next;
    logic [OUT_W-1:0] head_reg, head_next;
    logic [OUT_W-1:0] tail_reg, tail_next;
    logic [OUT_W-1:0] ext_word;
    logic             accept;
    logic             deliver;
    logic             load_head;
    logic             load_tail;
    logic             shift_tail;

    ext_fill_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_fill (
        .in_data  (in_data),
        .mode     (in_mode),
        .out_data (ext_word)
    );

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= OCC_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OCC_EMPTY: if (accept) state_next = OCC_ONE;
            OCC_ONE: begin
                if (accept && !deliver) begin
                    state_next = OCC_TWO;
                end else if (!accept && deliver) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_TWO:   if (deliver) state_next = OCC_ONE;
            default:   state_next = OCC_EMPTY;
        endcase
    end

    // Handshake outputs decode only the registered occupancy.
    always_comb begin
        in_ready  = (state_reg != OCC_TWO);
        out_valid = (state_reg != OCC_EMPTY);
    end

    // The head is the presented word; it is only written when it is empty or leaving,
    // so it holds under stall and keeps its last value after the final delivery.
    always_comb begin
        load_head  = accept && ((state_reg == OCC_EMPTY) || ((state_reg == OCC_ONE) && deliver));
        load_tail  = accept && (state_reg == OCC_ONE) && !deliver;
        shift_tail = deliver && (state_reg == OCC_TWO);
        head_next  = head_reg;
        tail_next  = tail_reg;
        if (load_head) begin
            head_next = ext_word;
        end else if (shift_tail) begin
            head_next = tail_reg;
        end
        if (load_tail) begin
            tail_next = ext_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    assign out_data = head_reg;

`ifdef EXT_STATS_EN
    logic             head_neg_reg, head_neg_next;
    logic             tail_neg_reg, tail_neg_next;
    logic [CNT_W-1:0] cnt_beats_reg;
    logic [CNT_W-1:0] cnt_neg_reg;

    // The sign flag travels with its entry exactly like the data word.
    always_comb begin
        head_neg_next = head_neg_reg;
        tail_neg_next = tail_neg_reg;
        if (load_head) begin
            head_neg_next = in_data[IN_W-1];
        end else if (shift_tail) begin
            head_neg_next = tail_neg_reg;
        end
        if (load_tail) begin
            tail_neg_next = in_data[IN_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_neg_reg  <= 1'b0;
            tail_neg_reg  <= 1'b0;
            cnt_beats_reg <= '0;
            cnt_neg_reg   <= '0;
        end else begin
            head_neg_reg <= head_neg_next;
            tail_neg_reg <= tail_neg_next;
            if (deliver) begin
                cnt_beats_reg <= cnt_beats_reg + 1'b1;
                if (head_neg_reg) begin
                    cnt_neg_reg <= cnt_neg_reg + 1'b1;
                end
            end
        end
    end

    assign cnt_beats = cnt_beats_reg;
    assign cnt_neg   = cnt_neg_reg;
`endif

endmodule

// File: tb/tb_ext_stream_pipe.sv
// Scoreboard bench for ext_stream_pipe (8->16 main instance, 16->32 side instance).
// Build with EXT_STATS_EN defined to also check the wrap-around statistics counters.
module tb_ext_stream_pipe;

`ifdef EXT_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [15:0] w_in_data = '0;
    logic [1:0]  w_in_mode = '0;
    logic        w_out_valid;
    logic [31:0] w_out_data;

`ifdef EXT_STATS_EN
    logic [CNT_W-1:0] cnt_beats, cnt_neg;
    logic [15:0]      w_cnt_beats, w_cnt_neg;
`endif

    always #5 clk = ~clk;

    ext_stream_pipe #(.IN_W(8), .OUT_W(16), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef EXT_STATS_EN
        .cnt_beats (cnt_beats),
        .cnt_neg   (cnt_neg),
`endif
        .out_data  (out_data)
    );

    ext_stream_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(16)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_data),
        .in_mode   (w_in_mode),
        .out_valid (w_out_valid),
        .out_ready (1'b1),
`ifdef EXT_STATS_EN
        .cnt_beats (w_cnt_beats),
        .cnt_neg   (w_cnt_neg),
`endif
        .out_data  (w_out_data)
    );

    typedef struct {
        logic [15:0] data;
        logic        neg;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   delivered = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension straight from the fill rule.
    function automatic logic [15:0] model8(input logic [7:0] d, input logic [1:0] m);
        logic fill;
        logic [15:0] r;
        fill = (m == 2'b00) ? 1'b0 : (m == 2'b10) ? 1'b1 : d[7];
        r = {16{fill}};
        r[7:0] = d;
        return r;
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] d, input logic [1:0] m);
        logic fill;
        logic [31:0] r;
        fill = (m == 2'b00) ? 1'b0 : (m == 2'b10) ? 1'b1 : d[15];
        r = {32{fill}};
        r[15:0] = d;
        return r;
    endfunction

    // Expected entries are pushed at the accepting edge.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back('{data: model8(in_data, in_mode), neg: in_data[7]});
        end
    end

    // Monitor: occupancy, stall stability, counters and ordered delivery.
    logic             prev_stall = 1'b0;
    logic [15:0]      prev_data = '0;
    logic [CNT_W-1:0] m_beats = '0;
    logic [CNT_W-1:0] m_neg = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            m_beats = '0;
            m_neg = '0;
        end else begin
            chk("occ_out_valid", out_valid, sb_q.size() != 0);
            chk("occ_in_ready", in_ready, sb_q.size() < 2);
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
            end
`ifdef EXT_STATS_EN
            chk("cnt_beats", cnt_beats, m_beats);
            chk("cnt_neg", cnt_neg, m_neg);
`endif
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", out_data, 64'hDEAD);
                end else begin
                    e = sb_q.pop_front();
                    chk("deliver_data", out_data, e.data);
                    $display("deliver #%0d data=%h", delivered, out_data);
                    delivered++;
                    m_beats = m_beats + 1'b1;
                    if (e.neg) m_neg = m_neg + 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m);
        int  n;
        bit  ok;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_mode = m;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_mode = 2'($urandom);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, sb_q.size(), 0);
    endtask

    bit rand_done;

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        cycles(2);

        // Directed beats with a free-running consumer.
        out_ready = 1'b1;
        send(8'h81, 2'b01);
        send(8'h81, 2'b00);
        send(8'h81, 2'b10);
        send(8'h7F, 2'b01);
        send(8'h5A, 2'b11);
        drain("t1_drain");
        cycles(2);

        // Fill the buffer against a stalled consumer, then release.
        out_ready = 1'b0;
        send(8'h01, 2'b01);
        send(8'hFF, 2'b01);
        @(negedge clk);
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_head", out_data, model8(8'h01, 2'b01));
        @(posedge clk);
        #1;
        fork
            send(8'hC3, 2'b01);
            begin
                cycles(3);
                out_ready = 1'b1;
            end
        join
        drain("t2_drain");

        // Randomised producer and consumer.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) cycles(1);
                    send(8'($urandom), 2'($urandom));
                end
                drain("t3_drain");
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    cycles(1);
                end
            end
        join
        out_ready = 1'b1;
        cycles(2);

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        send(8'h11, 2'b00);
        send(8'h92, 2'b01);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("t4_out_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        out_ready = 1'b1;
        cycles(2);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cycles(6);

        // Wide instance, 16 -> 32.
        w_in_valid = 1'b1;
        w_in_data = 16'hC00C;
        w_in_mode = 2'b01;
        @(negedge clk);
        chk("w_in_ready", w_in_ready, 1);
        @(posedge clk);
        #1;
        w_in_data = 16'h4004;
        w_in_mode = 2'b00;
        @(negedge clk);
        chk("w_valid0", w_out_valid, 1);
        chk("w_data0", w_out_data, model16(16'hC00C, 2'b01));
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        @(negedge clk);
        chk("w_valid1", w_out_valid, 1);
        chk("w_data1", w_out_data, model16(16'h4004, 2'b00));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w_idle", w_out_valid, 0);

`ifdef EXT_STATS_EN
        // 17 beats, 9 negative, from a fresh reset so the counters wrap once.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        cycles(2);
        for (int i = 0; i < 17; i++) begin
            send((i < 9) ? 8'h80 | 8'(i) : 8'(i), 2'b00);
        end
        drain("t6_drain");
        @(negedge clk);
        chk("t6_beats", cnt_beats, 4'd1);
        chk("t6_neg", cnt_neg, 4'd9);
`endif

        cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
